// File: rtl/halt_pkg.sv
// Shared types and constants for the halt controller.
package halt_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } halt_state_t;

  localparam int unsigned HALT_CODE_OK = 0;

endpackage

// File: rtl/halt_cycle_counter.sv
// Saturating count of cycles with the core enabled.
module halt_cycle_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Halt decode, pipeline drain and sticky exit status for the core.
// HALT_CYCLE_COUNT_EN builds the RUN cycle counter behind CYCLES.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int OP_WIDTH     = 32,
  parameter int CODE_WIDTH   = 3,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OP_WIDTH-1:0]   OP_CODE,
  input  logic                  HALT,
  input  logic                  RESUME,
  output logic                  RUN,
  output logic                  OK,
  output logic                  ERROR,
  output logic [CODE_WIDTH-1:0] EXIT_CODE,
  output logic [CNT_WIDTH-1:0]  CYCLES
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DLOAD =
    (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DLOAD);
  localparam logic [CODE_WIDTH-1:0] CODE_OK =
    CODE_WIDTH'(HALT_CODE_OK);

  halt_state_t           state;
  logic [DW-1:0]         drain_cnt;
  logic [CODE_WIDTH-1:0] code;
  logic                  unused_op;

  assign code = OP_CODE[CODE_WIDTH-1:0];

  // Opcode bits above the code field never reach the status.
  generate
    if (OP_WIDTH > CODE_WIDTH) begin : g_upper
      assign unused_op = ^OP_CODE[OP_WIDTH-1:CODE_WIDTH];
    end else begin : g_no_upper
      assign unused_op = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      RUN       <= 1'b1;
      OK        <= 1'b0;
      ERROR     <= 1'b0;
      EXIT_CODE <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (HALT) begin
            EXIT_CODE <= code;
            RUN       <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              state <= S_HALTED;
              OK    <= (code == CODE_OK);
              ERROR <= (code != CODE_OK);
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_HALTED;
            OK    <= (EXIT_CODE == CODE_OK);
            ERROR <= (EXIT_CODE != CODE_OK);
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_HALTED: begin
          // Core is stopped here, so a concurrent HALT is stale.
          if (RESUME) begin
            state <= S_RUN;
            RUN   <= 1'b1;
            OK    <= 1'b0;
            ERROR <= 1'b0;
          end
        end
        default: begin
          state <= S_RUN;
          RUN   <= 1'b1;
          OK    <= 1'b0;
          ERROR <= 1'b0;
        end
      endcase
    end
  end

`ifdef HALT_CYCLE_COUNT_EN
  halt_cycle_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .en    (RUN),
    .count (CYCLES)
  );
`else
  assign CYCLES = '0;
`endif

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: drain timing, status, resume, reset.
module tb_halt_ctrl;

`ifdef HALT_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op;
  logic        halt;
  logic        resume;

  logic        run, ok, err;
  logic [2:0]  exit_code;
  logic [31:0] cycles;

  logic        run0, ok0, err0;
  logic [2:0]  exit0;
  logic [31:0] cycles0;

  logic        run4, ok4, err4;
  logic [2:0]  exit4;
  logic [3:0]  cycles4;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  halt_ctrl #(
    .OP_WIDTH(32), .CODE_WIDTH(3),
    .DRAIN_CYCLES(2), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .OP_CODE(op),
    .HALT(halt), .RESUME(resume),
    .RUN(run), .OK(ok), .ERROR(err),
    .EXIT_CODE(exit_code), .CYCLES(cycles)
  );

  halt_ctrl #(
    .OP_WIDTH(32), .CODE_WIDTH(3),
    .DRAIN_CYCLES(0), .CNT_WIDTH(32)
  ) dut0 (
    .clk(clk), .rst(rst), .OP_CODE(op),
    .HALT(halt), .RESUME(resume),
    .RUN(run0), .OK(ok0), .ERROR(err0),
    .EXIT_CODE(exit0), .CYCLES(cycles0)
  );

  halt_ctrl #(
    .OP_WIDTH(32), .CODE_WIDTH(3),
    .DRAIN_CYCLES(2), .CNT_WIDTH(4)
  ) dut4 (
    .clk(clk), .rst(rst), .OP_CODE(op),
    .HALT(halt), .RESUME(resume),
    .RUN(run4), .OK(ok4), .ERROR(err4),
    .EXIT_CODE(exit4), .CYCLES(cycles4)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".run"}, 64'(run), 64'd1);
    check({tag, ".ok"}, 64'(ok), 64'd0);
    check({tag, ".err"}, 64'(err), 64'd0);
    check({tag, ".exit"}, 64'(exit_code), 64'd0);
    check({tag, ".cyc"}, 64'(cycles), 64'd0);
  endtask

  initial begin
    rst    = 1'b0;
    op     = '0;
    halt   = 1'b0;
    resume = 1'b0;
    tick();
    reset_checks("rst0");
    rst = 1'b1;

    // Idle, with stray RESUME while running
    for (int i = 0; i < 5; i++) begin
      resume = (i < 2);
      tick();
    end
    resume = 1'b0;
    check("idle.run", 64'(run), 64'd1);
    check("idle.ok", 64'(ok), 64'd0);

    // Halt with code 0
    op   = 32'h0000_0000;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h0.run", 64'(run), 64'd0);
    check("h0.ok_e0", 64'(ok), 64'd0);
    check("h0.d0_ok", 64'(ok0), 64'd1);
    tick();
    check("h0.ok_e1", 64'(ok), 64'd0);
    tick();
    check("h0.ok", 64'(ok), 64'd1);
    check("h0.err", 64'(err), 64'd0);
    check("h0.exit", 64'(exit_code), 64'd0);
    check("h0.cyc", 64'(cycles),
          CNT_EN ? 64'd6 : 64'd0);
    tick();
    check("h0.hold", 64'(ok), 64'd1);

    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("r0.run", 64'(run), 64'd1);
    check("r0.ok", 64'(ok), 64'd0);

    // Halt code 5 with upper bits set
    op   = 32'hFFFF_FF05;
    halt = 1'b1;
    tick();
    check("h5.d0_err", 64'(err0), 64'd1);
    check("h5.d0_ok", 64'(ok0), 64'd0);
    check("h5.d0_exit", 64'(exit0), 64'd5);
    // HALT and RESUME during drain; dut0 sees both while halted
    op     = 32'h0000_0001;
    resume = 1'b1;
    tick();
    halt   = 1'b0;
    resume = 1'b0;
    check("h5.drain_ok", 64'(ok), 64'd0);
    check("h5.drain_run", 64'(run), 64'd0);
    check("h5.d0_run", 64'(run0), 64'd1);
    check("h5.d0_clr", 64'(err0), 64'd0);
    check("h5.d0_keep", 64'(exit0), 64'd5);
    tick();
    check("h5.err", 64'(err), 64'd1);
    check("h5.ok", 64'(ok), 64'd0);
    check("h5.exit", 64'(exit_code), 64'd5);

    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("r5.run", 64'(run), 64'd1);
    check("r5.err", 64'(err), 64'd0);
    check("r5.ok", 64'(ok), 64'd0);
    check("r5.exit", 64'(exit_code), 64'd5);

    // Second halt, code 1
    op   = 32'h0000_0001;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h1.d0_exit", 64'(exit0), 64'd1);
    tick();
    tick();
    check("h1.err", 64'(err), 64'd1);
    check("h1.exit", 64'(exit_code), 64'd1);

    // Reset mid-drain
    resume = 1'b1;
    tick();
    resume = 1'b0;
    op   = 32'h0000_0002;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    rst  = 1'b0;
    tick();
    rst = 1'b1;
    reset_checks("rst_drain");
    tick();
    tick();
    check("rst_drain.ok", 64'(ok), 64'd0);
    check("rst_drain.err", 64'(err), 64'd0);

    // Reset while ERROR is high
    op   = 32'h0000_0003;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    tick();
    check("h3.err", 64'(err), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    reset_checks("rst_halt");

    // HALT together with reset is dropped
    halt = 1'b1;
    rst  = 1'b0;
    tick();
    rst  = 1'b1;
    halt = 1'b0;
    check("rh.run", 64'(run), 64'd1);
    check("rh.exit", 64'(exit_code), 64'd0);
    tick();
    tick();
    check("rh.run2", 64'(run), 64'd1);
    check("rh.err", 64'(err), 64'd0);

    // Counter saturation on the 4-bit instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("sat.c4", 64'(cycles4),
          CNT_EN ? 64'd15 : 64'd0);
    check("sat.c32", 64'(cycles),
          CNT_EN ? 64'd20 : 64'd0);
    repeat (3) tick();
    check("sat.hold", 64'(cycles4),
          CNT_EN ? 64'd15 : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
